nts_engine_tx_buffer: RTL and testbench
=======================================

// Module: nts_engine_tx_buffer
// PURPOSE
//  Engine-side TX packet buffer; the responder end of the extractor's engine read interface.
//  The engine writes one response packet as 64-bit words, then offers it to the extractor.
//  The extractor streams the packet out and releases the buffer. One instance per nts_engine.
// PARAMETERS
//  ADDR_WIDTH      8   word address width; capacity 2**ADDR_WIDTH 64-bit words
//  DATA_WIDTH      64  word width; fixed to the MAC data width
// PORTS
//  i_clk                           in   1    clock
//  i_areset                        in   1    async reset, active-high
//  o_wr_ready                      out  1    buffer free, write accepted
//  i_wr_en                         in   1    write strobe, one word per cycle
//  i_wr_data                       in   64   packet word
//  i_wr_last                       in   1    qualifies i_wr_en: final word of packet
//  i_wr_last_bytes                 in   4    valid bytes in final word, 1..8; 0 coerced to 8
//  i_wr_discard                    in   1    abandon the packet under construction
//  o_dispatch_tx_packet_available  out  1    complete packet held
//  i_dispatch_tx_packet_read       in   1    extractor release pulse
//  o_dispatch_tx_fifo_empty        out  1    no unread words remain
//  i_dispatch_tx_fifo_rd_start     in   1    start/restart stream from word 0
//  o_dispatch_tx_fifo_rd_valid     out  1    rd_data valid this cycle
//  o_dispatch_tx_fifo_rd_data      out  64   streamed word
//  o_dispatch_tx_bytes_last_word   out  4    valid bytes in final word
//  o_stat_packets                  out  32   packets released by extractor (macro)
//  o_stat_dropped                  out  32   packets overflowed or discarded (macro)
// BEHAVIOUR
//  Reset values
//  - All outputs 0, except o_wr_ready=1 and o_dispatch_tx_fifo_empty=1. State IDLE.
//  - wr_ptr, rd_ptr, word_count (ADDR_WIDTH+1 bits) all 0.
//  FSM: IDLE -> WRITE -> AVAILABLE <-> READ; AVAILABLE/READ -> IDLE on packet_read.
//  IDLE
//  - o_wr_ready=1. First i_wr_en writes mem[0] and enters WRITE.
//  - If i_wr_last is set on that same first write, go directly to AVAILABLE.
//  WRITE
//  - Each i_wr_en writes mem[wr_ptr] and increments wr_ptr.
//  - i_wr_en & i_wr_last at cycle N:
//    - word_count = wr_ptr+1; bytes_last_word latched.
//    - o_wr_ready falls and o_dispatch_tx_packet_available rises at N+1.
//    - fifo_empty falls at N+1.
//  - Overflow: a write with wr_ptr == 2**ADDR_WIDTH and no i_wr_last drops the packet.
//    Return to IDLE, increment dropped. The full-capacity last write itself is legal.
//  - i_wr_discard in IDLE/WRITE: return to IDLE, pointers cleared, dropped+1.
//  - i_wr_discard has priority over a simultaneous i_wr_en.
//  AVAILABLE
//  - Writes and discard ignored. rd_start at N: rd_ptr=0, enter READ.
//  - o_dispatch_tx_fifo_rd_valid high N+1 .. N+word_count, contiguous, words in write order.
//  READ
//  - Registered RAM read, one word per cycle. fifo_empty rises with the last rd_valid cycle.
//  - After the last word: back to AVAILABLE, fifo_empty=1, packet_available stays 1.
//  - rd_start during READ restarts from word 0; next cycle carries word 0.
//  - packet_read in AVAILABLE or READ at N:
//    - Streaming aborted; rd_valid=0 at N+1.
//    - packet_available=0, fifo_empty=1, o_wr_ready=1 at N+1; packets+1.
//  - packet_read in IDLE/WRITE is ignored.
//  Simultaneous events
//  - rd_start and packet_read in the same cycle: packet_read wins.
//  Output stability
//  - rd_data holds its last value when rd_valid=0.
//  - bytes_last_word is stable while packet_available=1, 0 otherwise.
//  Reset mid-operation
//  - Immediate return to reset values; the held packet is lost; counters cleared.
// CONFIGURATION
//  NTS_TX_BUFFER_STATS_EN defined:
//  - o_stat_packets / o_stat_dropped are 32-bit counters, wrap at 2**32, cleared by reset.
//  Not defined:
//  - Both ports tied to 0; no counter flops synthesised.
// TESTING
//  1. Write 6 words, last_bytes=2 -> available=1 next cycle, bytes_last_word=2; rd_start ->
//     6 contiguous rd_valid starting 1 cycle later, data matches; fifo_empty=1 after; packet_read -> wr_ready=1.
//  2. Write 2**ADDR_WIDTH words, last on the final word -> accepted.
//     One extra word without last -> dropped=1, state IDLE, available=0.
//  3. rd_start, then rd_start again after 3 words -> stream restarts at word 0;
//     a full second read after completion repeats identical data.
//  4. packet_read mid-stream (word 2 of 10) -> rd_valid=0 next cycle, available=0, wr_ready=1, packets=1.
//  5. Discard after 4 words, then write 1 word with last and last_bytes=0 ->
//     dropped=1, bytes_last_word=8, word_count=1; rd_start and packet_read in same cycle -> released, no rd_valid.
//  6. Assert i_areset during READ -> all outputs at reset values, fifo_empty=1, counters 0.

Source files
------------

// File: rtl/nts_engine_tx_buffer.sv
// rtl/nts_engine_tx_buffer.sv - engine-side single-packet TX buffer streamed out by the extractor
// Optional statistics counters are enabled by defining NTS_TX_BUFFER_STATS_EN.
module nts_engine_tx_buffer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_areset,
    output logic                  o_wr_ready,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_wr_last,
    input  logic [3:0]            i_wr_last_bytes,
    input  logic                  i_wr_discard,
    output logic                  o_dispatch_tx_packet_available,
    input  logic                  i_dispatch_tx_packet_read,
    output logic                  o_dispatch_tx_fifo_empty,
    input  logic                  i_dispatch_tx_fifo_rd_start,
    output logic                  o_dispatch_tx_fifo_rd_valid,
    output logic [DATA_WIDTH-1:0] o_dispatch_tx_fifo_rd_data,
    output logic [3:0]            o_dispatch_tx_bytes_last_word,
    output logic [31:0]           o_stat_packets,
    output logic [31:0]           o_stat_dropped
);

    localparam logic [1:0] STATE_IDLE      = 2'd0;
    localparam logic [1:0] STATE_WRITE     = 2'd1;
    localparam logic [1:0] STATE_AVAILABLE = 2'd2;
    localparam logic [1:0] STATE_READ      = 2'd3;

    localparam int DEPTH = 1 << ADDR_WIDTH;
    // Pointer value one past the last storable word.
    localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [1:0]            state;
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   word_count;
    logic [3:0]            bytes_last_word;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic                  writing;
    logic                  wr_accept;
    logic [ADDR_WIDTH:0]   fetch_idx;
    logic [ADDR_WIDTH:0]   fetch_next;

    // Write-side acceptance and the read address for this cycle (rd_start rewinds to word 0).
    always_comb begin
        writing    = (state == STATE_IDLE) || (state == STATE_WRITE);
        wr_accept  = writing && i_wr_en && !i_wr_discard && (wr_ptr != CAPACITY);
        fetch_idx  = i_dispatch_tx_fifo_rd_start ? '0 : rd_ptr;
        fetch_next = fetch_idx + PTR_ONE;
    end

    // Packet storage; no reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (wr_accept) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= i_wr_data;
        end
    end

    // Buffer FSM: fill, hold, stream with registered read, release.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state           <= STATE_IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            word_count      <= '0;
            bytes_last_word <= 4'd0;
            rd_valid        <= 1'b0;
            rd_data         <= '0;
            fifo_empty      <= 1'b1;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                STATE_IDLE, STATE_WRITE: begin
                    if (i_wr_discard) begin
                        state  <= STATE_IDLE;
                        wr_ptr <= '0;
                    end else if (i_wr_en) begin
                        if (wr_ptr == CAPACITY) begin
                            // No room for another word: the packet is dropped.
                            state  <= STATE_IDLE;
                            wr_ptr <= '0;
                        end else begin
                            wr_ptr <= wr_ptr + PTR_ONE;
                            if (i_wr_last) begin
                                state           <= STATE_AVAILABLE;
                                word_count      <= wr_ptr + PTR_ONE;
                                bytes_last_word <= (i_wr_last_bytes == 4'd0) ? 4'd8 : i_wr_last_bytes;
                                fifo_empty      <= 1'b0;
                            end else begin
                                state <= STATE_WRITE;
                            end
                        end
                    end
                end
                default: begin
                    if (i_dispatch_tx_packet_read) begin
                        state           <= STATE_IDLE;
                        wr_ptr          <= '0;
                        rd_ptr          <= '0;
                        word_count      <= '0;
                        bytes_last_word <= 4'd0;
                        fifo_empty      <= 1'b1;
                    end else if (i_dispatch_tx_fifo_rd_start || (state == STATE_READ)) begin
                        rd_data  <= mem[fetch_idx[ADDR_WIDTH-1:0]];
                        rd_valid <= 1'b1;
                        rd_ptr   <= fetch_next;
                        if (fetch_next == word_count) begin
                            // Final word issued: empty rises alongside its rd_valid cycle.
                            state      <= STATE_AVAILABLE;
                            fifo_empty <= 1'b1;
                        end else begin
                            state      <= STATE_READ;
                            fifo_empty <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign o_wr_ready                     = (state == STATE_IDLE) || (state == STATE_WRITE);
    assign o_dispatch_tx_packet_available = (state == STATE_AVAILABLE) || (state == STATE_READ);
    assign o_dispatch_tx_fifo_empty       = fifo_empty;
    assign o_dispatch_tx_fifo_rd_valid    = rd_valid;
    assign o_dispatch_tx_fifo_rd_data     = rd_data;
    assign o_dispatch_tx_bytes_last_word  = bytes_last_word;

`ifdef NTS_TX_BUFFER_STATS_EN
    logic        pkt_inc;
    logic        drop_inc;
    logic [31:0] stat_packets;
    logic [31:0] stat_dropped;

    assign pkt_inc  = !writing && i_dispatch_tx_packet_read;
    assign drop_inc = writing && (i_wr_discard || (i_wr_en && (wr_ptr == CAPACITY)));

    // Released and dropped packet counters, free-running with natural wrap.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            stat_packets <= 32'd0;
            stat_dropped <= 32'd0;
        end else begin
            if (pkt_inc) begin
                stat_packets <= stat_packets + 32'd1;
            end
            if (drop_inc) begin
                stat_dropped <= stat_dropped + 32'd1;
            end
        end
    end

    assign o_stat_packets = stat_packets;
    assign o_stat_dropped = stat_dropped;
`else
    assign o_stat_packets = 32'd0;
    assign o_stat_dropped = 32'd0;
`endif

endmodule

// File: tb/tb_nts_engine_tx_buffer.sv
// tb/tb_nts_engine_tx_buffer.sv - self-checking bench for nts_engine_tx_buffer
module tb_nts_engine_tx_buffer;

`ifdef NTS_TX_BUFFER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam int CAP = 256;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        wr_ready;
    logic        wr_en = 1'b0;
    logic [63:0] wr_data = '0;
    logic        wr_last = 1'b0;
    logic [3:0]  wr_last_bytes = '0;
    logic        wr_discard = 1'b0;
    logic        avail;
    logic        pkt_read = 1'b0;
    logic        empty;
    logic        rd_start = 1'b0;
    logic        rd_valid;
    logic [63:0] rd_data;
    logic [3:0]  bytes_lw;
    logic [31:0] stat_p;
    logic [31:0] stat_d;

    int          total = 0;
    int          bad = 0;
    logic [63:0] exp_q[$];
    int          exp_pk = 0;
    int          exp_dr = 0;
    logic [3:0]  exp_bytes = '0;

    nts_engine_tx_buffer dut (
        .i_clk                          (clk),
        .i_areset                       (areset),
        .o_wr_ready                     (wr_ready),
        .i_wr_en                        (wr_en),
        .i_wr_data                      (wr_data),
        .i_wr_last                      (wr_last),
        .i_wr_last_bytes                (wr_last_bytes),
        .i_wr_discard                   (wr_discard),
        .o_dispatch_tx_packet_available (avail),
        .i_dispatch_tx_packet_read      (pkt_read),
        .o_dispatch_tx_fifo_empty       (empty),
        .i_dispatch_tx_fifo_rd_start    (rd_start),
        .o_dispatch_tx_fifo_rd_valid    (rd_valid),
        .o_dispatch_tx_fifo_rd_data     (rd_data),
        .o_dispatch_tx_bytes_last_word  (bytes_lw),
        .o_stat_packets                 (stat_p),
        .o_stat_dropped                 (stat_d)
    );

    always #5 clk = ~clk;

    task automatic write_pkt(input int n, input bit with_last, input logic [3:0] lb);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            wr_en         = 1'b1;
            wr_data       = {$urandom, $urandom};
            wr_last       = with_last && (i == n - 1);
            wr_last_bytes = lb;
            exp_q.push_back(wr_data);
            @(negedge clk);
        end
        wr_en   = 1'b0;
        wr_last = 1'b0;
        if (with_last) exp_bytes = (lb == 4'd0) ? 4'd8 : lb;
    endtask

    task automatic check_avail(input string name);
        total++;
        if ({avail, wr_ready, empty, bytes_lw} !== {1'b1, 1'b0, 1'b0, exp_bytes}) begin
            bad++;
            $display("FAIL %s avail/ready/empty/bytes got=%b want=%b", name,
                     {avail, wr_ready, empty, bytes_lw}, {1'b1, 1'b0, 1'b0, exp_bytes});
        end
    endtask

    task automatic check_stats(input string name);
        logic [31:0] ep;
        logic [31:0] ed;
        ep = STATS ? exp_pk[31:0] : 32'd0;
        ed = STATS ? exp_dr[31:0] : 32'd0;
        total++;
        if ({stat_p, stat_d} !== {ep, ed}) begin
            bad++;
            $display("FAIL %s stats got=%0d/%0d want=%0d/%0d", name, stat_p, stat_d, ep, ed);
        end
    endtask

    // Pulse rd_start and observe n_obs cycles; word c of the packet is due at observation c.
    task automatic read_stream(input string name, input int n_exp, input int n_obs);
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        for (int c = 0; c < n_obs; c++) begin
            total++;
            if (c < n_exp) begin
                if ({rd_valid, rd_data, empty} !== {1'b1, exp_q[c], (c == n_exp - 1)}) begin
                    bad++;
                    $display("FAIL %s word%0d valid/data/empty got=%b/%h/%b want=1/%h/%b", name, c,
                             rd_valid, rd_data, empty, exp_q[c], (c == n_exp - 1));
                end
            end else begin
                if ({rd_valid, rd_data, empty, avail} !== {1'b0, exp_q[n_exp-1], 1'b1, 1'b1}) begin
                    bad++;
                    $display("FAIL %s idle%0d valid/data/empty/avail got=%b/%h/%b/%b want=0/%h/1/1",
                             name, c, rd_valid, rd_data, empty, avail, exp_q[n_exp-1]);
                end
            end
            if (c != n_obs - 1) @(negedge clk);
        end
    endtask

    task automatic release_pkt(input string name);
        pkt_read = 1'b1;
        @(negedge clk);
        pkt_read = 1'b0;
        exp_pk++;
        total++;
        if ({avail, wr_ready, empty, rd_valid, bytes_lw} !== {1'b0, 1'b1, 1'b1, 1'b0, 4'd0}) begin
            bad++;
            $display("FAIL %s release avail/ready/empty/valid/bytes got=%b want=01100000", name,
                     {avail, wr_ready, empty, rd_valid, bytes_lw});
        end
        check_stats(name);
    endtask

    task automatic test_reset;
        total++;
        if ({wr_ready, avail, empty, rd_valid, rd_data, bytes_lw, stat_p, stat_d} !==
            {1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 4'd0, 32'd0, 32'd0}) begin
            bad++;
            $display("FAIL reset_values got ready=%b avail=%b empty=%b valid=%b data=%h bytes=%0d p=%0d d=%0d",
                     wr_ready, avail, empty, rd_valid, rd_data, bytes_lw, stat_p, stat_d);
        end
    endtask

    task automatic test_basic;
        write_pkt(6, 1'b1, 4'd2);
        check_avail("basic");
        read_stream("basic", 6, 8);
        release_pkt("basic");
    endtask

    task automatic test_full;
        write_pkt(CAP, 1'b1, 4'd5);
        check_avail("full");
        read_stream("full", CAP, CAP + 2);
        release_pkt("full");
        write_pkt(CAP, 1'b0, 4'd0);
        total++;
        if ({avail, wr_ready} !== 2'b01) begin
            bad++;
            $display("FAIL full_nolast avail/ready got=%b want=01", {avail, wr_ready});
        end
        wr_en   = 1'b1;
        wr_data = {$urandom, $urandom};
        @(negedge clk);
        wr_en = 1'b0;
        exp_dr++;
        total++;
        if ({avail, wr_ready, empty} !== 3'b011) begin
            bad++;
            $display("FAIL overflow avail/ready/empty got=%b want=011", {avail, wr_ready, empty});
        end
        check_stats("overflow");
        write_pkt(2, 1'b1, 4'd3);
        check_avail("after_overflow");
        read_stream("after_overflow", 2, 4);
        release_pkt("after_overflow");
    endtask

    task automatic test_restart;
        write_pkt(10, 1'b1, 4'd7);
        check_avail("restart");
        read_stream("restart_part", 10, 3);
        read_stream("restart_full", 10, 12);
        read_stream("repeat_full", 10, 12);
        release_pkt("restart");
    endtask

    task automatic test_abort;
        write_pkt(10, 1'b1, 4'd1);
        check_avail("abort");
        read_stream("abort", 10, 3);
        release_pkt("abort");
    endtask

    task automatic test_discard;
        write_pkt(4, 1'b0, 4'd0);
        wr_en      = 1'b1;
        wr_discard = 1'b1;
        wr_data    = {$urandom, $urandom};
        @(negedge clk);
        wr_en      = 1'b0;
        wr_discard = 1'b0;
        exp_dr++;
        total++;
        if ({avail, wr_ready, empty} !== 3'b011) begin
            bad++;
            $display("FAIL discard avail/ready/empty got=%b want=011", {avail, wr_ready, empty});
        end
        check_stats("discard");
        write_pkt(1, 1'b1, 4'd0);
        check_avail("one_word");
        read_stream("one_word", 1, 3);
        rd_start = 1'b1;
        pkt_read = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        pkt_read = 1'b0;
        exp_pk++;
        for (int c = 0; c < 2; c++) begin
            total++;
            if ({rd_valid, avail, wr_ready, empty} !== 4'b0011) begin
                bad++;
                $display("FAIL start_and_read cyc%0d valid/avail/ready/empty got=%b want=0011", c,
                         {rd_valid, avail, wr_ready, empty});
            end
            @(negedge clk);
        end
        check_stats("start_and_read");
    endtask

    task automatic test_random;
        for (int it = 0; it < 12; it++) begin
            int         n;
            logic [3:0] lb;
            n  = $urandom_range(1, 24);
            lb = 4'($urandom_range(0, 8));
            if ($urandom_range(0, 3) == 0) begin
                write_pkt(n, 1'b0, 4'd0);
                wr_discard = 1'b1;
                @(negedge clk);
                wr_discard = 1'b0;
                exp_dr++;
                check_stats("rand_discard");
            end else begin
                write_pkt(n, 1'b1, lb);
                check_avail("rand");
                read_stream("rand", n, n + 2);
                release_pkt("rand");
            end
        end
    endtask

    task automatic test_reset_mid;
        write_pkt(5, 1'b1, 4'd4);
        read_stream("mid_read", 5, 2);
        #2 areset = 1'b1;
        #1;
        exp_pk = 0;
        exp_dr = 0;
        test_reset();
        @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
        test_reset();
        write_pkt(3, 1'b1, 4'd6);
        check_avail("post_reset");
        read_stream("post_reset", 3, 5);
        release_pkt("post_reset");
    endtask

    initial begin
        repeat (2) @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_full();
        test_restart();
        test_abort();
        test_discard();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
